// File: rtl/net_axis_if.sv
// AXI-stream bundle for the network-side frame path.
interface net_axis_if #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/net_rx_sink.sv
// Network-side receive endpoint: accepts one frame per descriptor under a fixed
// backpressure pattern, re-presents each beat and reports length/tlast/keep status.
module net_rx_sink #(
  parameter int unsigned AXIS_DATA_WIDTH = 512,
  parameter int unsigned AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int unsigned AXIS_USER_WIDTH = 8,
  parameter int unsigned LEN_WIDTH       = 20,
  parameter int unsigned ROWS            = 32,
  parameter int unsigned INPUT_LENGTH    = 16,
  parameter logic [15:0] READY_PATTERN   = 16'hFFFF
) (
  input  logic                          clk,
  input  logic                          rst,
  net_axis_if.slave                     s_net_axis,
  input  logic                          net_rstart,
  input  logic [LEN_WIDTH-1:0]          net_rdesc_len,
  output logic [ROWS*INPUT_LENGTH-1:0]  net_data_out,
  output logic                          net_valid_out,
  output logic [AXIS_KEEP_WIDTH-1:0]    net_data_tkeep_out,
  output logic                          net_data_tlast_out,
  output logic                          net_rx_busy,
  output logic                          net_rx_done,
  output logic [LEN_WIDTH-1:0]          net_rx_len,
  output logic [AXIS_USER_WIDTH-1:0]    net_rx_tuser,
  output logic                          net_rx_err_len,
  output logic                          net_rx_err_keep
);

  localparam logic [AXIS_KEEP_WIDTH-1:0] KeepOne = {{(AXIS_KEEP_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRecv, StDone} state_e;

  state_e               state;
  logic [3:0]           ptr;
  logic                 tready;
  logic [LEN_WIDTH-1:0] count;
  logic [LEN_WIDTH-1:0] exp_len;

  logic                 accept;
  logic [LEN_WIDTH:0]   keep_ones;
  logic [LEN_WIDTH:0]   count_sum;
  logic [LEN_WIDTH-1:0] count_next;
  logic                 keep_contig;
  logic                 keep_bad;

  assign s_net_axis.tready = tready;
  assign accept = s_net_axis.tvalid & tready;

  always_comb begin
    keep_ones = '0;
    for (int i = 0; i < AXIS_KEEP_WIDTH; i++) begin
      keep_ones = keep_ones + {{LEN_WIDTH{1'b0}}, s_net_axis.tkeep[i]};
    end
  end

  // One extra bit catches overflow so the count sticks at all-ones.
  assign count_sum  = {1'b0, count} + keep_ones;
  assign count_next = count_sum[LEN_WIDTH] ? '1 : count_sum[LEN_WIDTH-1:0];

  // A run of ones from bit 0 has no set bit left after adding one to it.
  assign keep_contig = ((s_net_axis.tkeep & (s_net_axis.tkeep + KeepOne)) == '0);
  assign keep_bad    = !keep_contig || (!s_net_axis.tlast && !(&s_net_axis.tkeep));

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= StIdle;
      ptr                <= '0;
      tready             <= 1'b0;
      count              <= '0;
      exp_len            <= '0;
      net_data_out       <= '0;
      net_valid_out      <= 1'b0;
      net_data_tkeep_out <= '0;
      net_data_tlast_out <= 1'b0;
      net_rx_busy        <= 1'b0;
      net_rx_done        <= 1'b0;
      net_rx_len         <= '0;
      net_rx_tuser       <= '0;
      net_rx_err_len     <= 1'b0;
      net_rx_err_keep    <= 1'b0;
    end else begin
      net_valid_out <= 1'b0;
      net_rx_done   <= 1'b0;
      unique case (state)
        StIdle: begin
          if (net_rstart) begin
            count           <= '0;
            net_rx_len      <= '0;
            net_rx_err_len  <= 1'b0;
            net_rx_err_keep <= 1'b0;
            if (net_rdesc_len != '0) begin
              exp_len     <= net_rdesc_len;
              ptr         <= '0;
              tready      <= READY_PATTERN[0];
              net_rx_busy <= 1'b1;
              state       <= StRecv;
            end else begin
              net_rx_done <= 1'b1;
              state       <= StDone;
            end
          end
        end
        StRecv: begin
          ptr    <= ptr + 4'd1;
          // tready is registered, so load the bit for the coming RECV cycle.
          tready <= READY_PATTERN[ptr + 4'd1];
          if (accept) begin
            net_data_out       <= s_net_axis.tdata;
            net_data_tkeep_out <= s_net_axis.tkeep;
            net_data_tlast_out <= s_net_axis.tlast;
            net_valid_out      <= 1'b1;
            count              <= count_next;
            if (keep_bad) begin
              net_rx_err_keep <= 1'b1;
            end
            if (s_net_axis.tlast) begin
              net_rx_tuser   <= s_net_axis.tuser;
              net_rx_len     <= count_next;
              net_rx_err_len <= (count_next != exp_len);
              net_rx_done    <= 1'b1;
              net_rx_busy    <= 1'b0;
              tready         <= 1'b0;
              state          <= StDone;
            end
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_net_rx_sink.sv
// Bench for net_rx_sink: two instances (full and alternating backpressure) checked
// every cycle against a transaction-level model, plus literal expectations per scenario.
module tb_net_rx_sink;
  localparam int unsigned DW = 512;
  localparam int unsigned KW = 64;
  localparam int unsigned UW = 8;
  localparam int unsigned LW = 20;
  localparam int MaxLen = (1 << LW) - 1;

  typedef logic [DW-1:0] wide_t;
  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          rstart [2];
  logic [LW-1:0] rlen   [2];
  logic [DW-1:0] tdata  [2];
  logic [KW-1:0] tkeep  [2];
  logic          tlast  [2];
  logic [UW-1:0] tuser  [2];
  logic          tvalid [2];
  logic          tready [2];

  logic [DW-1:0] d_out  [2];
  logic          v_out  [2];
  logic [KW-1:0] k_out  [2];
  logic          l_out  [2];
  logic          busy   [2];
  logic          done   [2];
  logic [LW-1:0] len_o  [2];
  logic [UW-1:0] user_o [2];
  logic          el     [2];
  logic          ek     [2];

  net_axis_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) ax0 ();
  net_axis_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) ax1 ();

  assign ax0.tdata = tdata[0];  assign ax1.tdata = tdata[1];
  assign ax0.tkeep = tkeep[0];  assign ax1.tkeep = tkeep[1];
  assign ax0.tlast = tlast[0];  assign ax1.tlast = tlast[1];
  assign ax0.tuser = tuser[0];  assign ax1.tuser = tuser[1];
  assign ax0.tvalid = tvalid[0]; assign ax1.tvalid = tvalid[1];
  assign tready[0] = ax0.tready; assign tready[1] = ax1.tready;

  net_rx_sink #(.READY_PATTERN(16'hFFFF)) u0 (
    .clk(clk), .rst(rst), .s_net_axis(ax0), .net_rstart(rstart[0]), .net_rdesc_len(rlen[0]),
    .net_data_out(d_out[0]), .net_valid_out(v_out[0]), .net_data_tkeep_out(k_out[0]),
    .net_data_tlast_out(l_out[0]), .net_rx_busy(busy[0]), .net_rx_done(done[0]),
    .net_rx_len(len_o[0]), .net_rx_tuser(user_o[0]), .net_rx_err_len(el[0]),
    .net_rx_err_keep(ek[0])
  );

  net_rx_sink #(.READY_PATTERN(16'h5555)) u1 (
    .clk(clk), .rst(rst), .s_net_axis(ax1), .net_rstart(rstart[1]), .net_rdesc_len(rlen[1]),
    .net_data_out(d_out[1]), .net_valid_out(v_out[1]), .net_data_tkeep_out(k_out[1]),
    .net_data_tlast_out(l_out[1]), .net_rx_busy(busy[1]), .net_rx_done(done[1]),
    .net_rx_len(len_o[1]), .net_rx_tuser(user_o[1]), .net_rx_err_len(el[1]),
    .net_rx_err_keep(ek[1])
  );

  int n_cmp;
  int n_fail;

  beat_t q0[$];
  beat_t q1[$];

  // Model: what each sink must show, derived from frame-level rules.
  logic [15:0]   pat    [2];
  bit            m_busy [2];
  int            m_cyc  [2];
  int            m_cnt  [2];
  int            m_exp  [2];
  bit            e_valid[2];
  logic [DW-1:0] e_data [2];
  logic [KW-1:0] e_keep [2];
  bit            e_last [2];
  bit            e_done [2];
  int            e_len  [2];
  logic [UW-1:0] e_user [2];
  bit            e_el   [2];
  bit            e_ek   [2];

  // Observations gathered at each sampling point.
  bit            seen_done[2];
  int            vcnt     [2];
  bit            rdy_seen [2];
  logic [LW-1:0] d_len    [2];
  logic [UW-1:0] d_user   [2];
  logic          d_el     [2];
  logic          d_ek     [2];
  logic          d_valid  [2];
  logic          s_valid  [2];
  logic          s_busy   [2];
  logic          s_done   [2];
  logic          s_rdy    [2];
  logic          s_el     [2];
  logic [LW-1:0] s_len    [2];
  logic [DW-1:0] s_data   [2];

  task automatic chk(string nm, int k, wide_t got, wide_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h want %h", nm, k, got, exp);
    end
  endtask

  function automatic bit contig(logic [KW-1:0] kp);
    int top = -1;
    for (int i = 0; i < int'(KW); i++) if (kp[i]) top = i;
    return $countones(kp) == top + 1;
  endfunction

  function automatic bit exp_rdy(int k);
    return m_busy[k] && pat[k][m_cyc[k] % 16];
  endfunction

  function automatic wide_t rnd512();
    wide_t w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic model_step(int k, bit r, bit st, int ln, bit acc, beat_t b);
    bit was_done = e_done[k];
    e_valid[k] = 0;
    e_done[k]  = 0;
    if (r) begin
      m_busy[k] = 0; m_cyc[k] = 0; m_cnt[k] = 0; m_exp[k] = 0;
      e_len[k] = 0; e_user[k] = '0; e_el[k] = 0; e_ek[k] = 0;
    end else if (m_busy[k]) begin
      m_cyc[k]++;
      if (acc) begin
        e_valid[k] = 1;
        e_data[k]  = b.data;
        e_keep[k]  = b.keep;
        e_last[k]  = b.last;
        m_cnt[k]   = m_cnt[k] + $countones(b.keep);
        if (m_cnt[k] > MaxLen) m_cnt[k] = MaxLen;
        if (!contig(b.keep) || (!b.last && b.keep != '1)) e_ek[k] = 1;
        if (b.last) begin
          e_user[k] = b.user;
          m_busy[k] = 0;
          e_done[k] = 1;
          e_len[k]  = m_cnt[k];
          e_el[k]   = (m_cnt[k] != m_exp[k]);
        end
      end
    end else if (!was_done && st) begin
      m_cnt[k] = 0; e_len[k] = 0; e_el[k] = 0; e_ek[k] = 0;
      if (ln != 0) begin
        m_busy[k] = 1; m_cyc[k] = 0; m_exp[k] = ln;
      end else begin
        e_done[k] = 1;
      end
    end
  endtask

  task automatic present(int k);
    beat_t b;
    bit have;
    have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    b = '{data: '0, keep: '0, last: 1'b0, user: '0};
    if (have) b = (k == 0) ? q0[0] : q1[0];
    tvalid[k] = have;
    tdata[k]  = b.data;
    tkeep[k]  = b.keep;
    tlast[k]  = b.last;
    tuser[k]  = b.user;
  endtask

  task automatic push(int k, logic [DW-1:0] d, logic [KW-1:0] kp, bit last, logic [UW-1:0] u);
    beat_t b;
    b = '{data: d, keep: kp, last: last, user: u};
    if (k == 0) q0.push_back(b); else q1.push_back(b);
    present(k);
  endtask

  task automatic flush(int k);
    if (k == 0) q0.delete(); else q1.delete();
    present(k);
  endtask

  task automatic tick();
    beat_t b[2];
    bit acc_dut[2];
    bit acc_m[2];
    bit st[2];
    int ln[2];
    bit r;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("tready", k, wide_t'(tready[k]), wide_t'(exp_rdy(k)));
      chk("busy", k, wide_t'(busy[k]), wide_t'(m_busy[k]));
      chk("valid", k, wide_t'(v_out[k]), wide_t'(e_valid[k]));
      if (e_valid[k]) begin
        chk("data", k, d_out[k], e_data[k]);
        chk("keep", k, wide_t'(k_out[k]), wide_t'(e_keep[k]));
        chk("last", k, wide_t'(l_out[k]), wide_t'(e_last[k]));
      end
      chk("done", k, wide_t'(done[k]), wide_t'(e_done[k]));
      chk("len", k, wide_t'(len_o[k]), wide_t'(e_len[k]));
      chk("tuser", k, wide_t'(user_o[k]), wide_t'(e_user[k]));
      chk("err_len", k, wide_t'(el[k]), wide_t'(e_el[k]));
      chk("err_keep", k, wide_t'(ek[k]), wide_t'(e_ek[k]));
      if (done[k] === 1'b1) begin
        seen_done[k] = 1;
        d_len[k] = len_o[k]; d_user[k] = user_o[k];
        d_el[k] = el[k]; d_ek[k] = ek[k]; d_valid[k] = v_out[k];
      end
      if (v_out[k] === 1'b1) vcnt[k]++;
      if (tready[k] === 1'b1) rdy_seen[k] = 1;
      s_valid[k] = v_out[k]; s_busy[k] = busy[k]; s_done[k] = done[k];
      s_rdy[k] = tready[k]; s_len[k] = len_o[k]; s_data[k] = d_out[k]; s_el[k] = el[k];
      acc_dut[k] = tvalid[k] && tready[k];
      acc_m[k]   = tvalid[k] && exp_rdy(k);
      b[k] = '{data: tdata[k], keep: tkeep[k], last: tlast[k], user: tuser[k]};
      st[k] = rstart[k];
      ln[k] = int'(rlen[k]);
    end
    r = rst;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      model_step(k, r, st[k], ln[k], acc_m[k], b[k]);
      if (acc_dut[k]) begin
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      present(k);
    end
  endtask

  task automatic run_until_done(int k, int budget, output int n);
    n = 0;
    while (!seen_done[k] && n < budget) begin
      tick();
      n++;
    end
    if (!seen_done[k]) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout[%0d]: got none within %0d cycles, want a done pulse", k, budget);
    end
  endtask

  task automatic run_frame(int k, int len, int budget, output int n);
    vcnt[k] = 0;
    rdy_seen[k] = 0;
    seen_done[k] = 0;
    rstart[k] = 1'b1;
    rlen[k] = LW'(len);
    tick();
    rstart[k] = 1'b0;
    run_until_done(k, budget, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, want finish");
    $fatal(1);
  end

  initial begin
    int n;
    n_cmp = 0;
    n_fail = 0;
    pat[0] = 16'hFFFF;
    pat[1] = 16'h5555;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rstart[k] = 1'b0; rlen[k] = '0;
      m_busy[k] = 0; m_cyc[k] = 0; m_cnt[k] = 0; m_exp[k] = 0;
      e_valid[k] = 0; e_data[k] = '0; e_keep[k] = '0; e_last[k] = 0; e_done[k] = 0;
      e_len[k] = 0; e_user[k] = '0; e_el[k] = 0; e_ek[k] = 0;
      seen_done[k] = 0; vcnt[k] = 0; rdy_seen[k] = 0;
      present(k);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_tready", 0, wide_t'(s_rdy[0]), '0);
    chk("rst_busy", 0, wide_t'(s_busy[0]), '0);
    chk("rst_valid", 1, wide_t'(s_valid[1]), '0);

    // Two full beats, queued while idle so they must stall first.
    push(0, rnd512(), '1, 1'b0, 8'h11);
    push(0, rnd512(), '1, 1'b1, 8'hA5);
    tick();
    tick();
    run_frame(0, 128, 20, n);
    chk("f1_latency", 0, wide_t'(n), wide_t'(3));
    chk("f1_len", 0, wide_t'(d_len[0]), wide_t'(128));
    chk("f1_err_len", 0, wide_t'(d_el[0]), '0);
    chk("f1_err_keep", 0, wide_t'(d_ek[0]), '0);
    chk("f1_valid_cnt", 0, wide_t'(vcnt[0]), wide_t'(2));
    chk("f1_tuser", 0, wide_t'(d_user[0]), wide_t'(8'hA5));
    chk("f1_valid_at_done", 0, wide_t'(d_valid[0]), wide_t'(1));

    // 64 + 36 bytes.
    push(0, rnd512(), '1, 1'b0, 8'h01);
    push(0, rnd512(), 64'h0000000F_FFFFFFFF, 1'b1, 8'h02);
    run_frame(0, 100, 20, n);
    chk("f2_len", 0, wide_t'(d_len[0]), wide_t'(100));
    chk("f2_err_len", 0, wide_t'(d_el[0]), '0);
    chk("f2_err_keep", 0, wide_t'(d_ek[0]), '0);

    // Longer than described, then a clean frame clears the error.
    push(0, rnd512(), '1, 1'b0, 8'h03);
    push(0, rnd512(), '1, 1'b1, 8'h04);
    run_frame(0, 64, 20, n);
    chk("f3_len", 0, wide_t'(d_len[0]), wide_t'(128));
    chk("f3_err_len", 0, wide_t'(d_el[0]), wide_t'(1));
    tick();
    tick();
    chk("f3_err_len_hold", 0, wide_t'(s_el[0]), wide_t'(1));
    push(0, rnd512(), '1, 1'b1, 8'h05);
    run_frame(0, 64, 20, n);
    chk("f3b_len", 0, wide_t'(d_len[0]), wide_t'(64));
    chk("f3b_err_len", 0, wide_t'(d_el[0]), '0);

    // Alternating ready: accepts on RECV cycles 0,2,4,6.
    for (int i = 0; i < 4; i++) push(1, rnd512(), '1, (i == 3), 8'(8'h40 + i));
    run_frame(1, 256, 40, n);
    chk("f4_latency", 1, wide_t'(n), wide_t'(8));
    chk("f4_valid_cnt", 1, wide_t'(vcnt[1]), wide_t'(4));
    chk("f4_len", 1, wide_t'(d_len[1]), wide_t'(256));
    chk("f4_tuser", 1, wide_t'(d_user[1]), wide_t'(8'h43));

    // Partial keep on a non-last beat, then a gapped keep.
    push(0, rnd512(), 64'h0F, 1'b0, 8'h06);
    push(0, rnd512(), 64'h0F00, 1'b1, 8'h07);
    run_frame(0, 8, 20, n);
    chk("f5_len", 0, wide_t'(d_len[0]), wide_t'(8));
    chk("f5_err_keep", 0, wide_t'(d_ek[0]), wide_t'(1));
    chk("f5_err_len", 0, wide_t'(d_el[0]), '0);

    // Reset after the first of three beats.
    for (int i = 0; i < 3; i++) push(0, rnd512(), '1, (i == 2), 8'h08);
    seen_done[0] = 0;
    rstart[0] = 1'b1;
    rlen[0] = LW'(192);
    tick();
    rstart[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    flush(0);
    tick();
    chk("f6_valid", 0, wide_t'(s_valid[0]), '0);
    chk("f6_busy", 0, wide_t'(s_busy[0]), '0);
    chk("f6_tready", 0, wide_t'(s_rdy[0]), '0);
    chk("f6_len", 0, wide_t'(s_len[0]), '0);
    chk("f6_data", 0, s_data[0], '0);
    chk("f6_no_done", 0, wide_t'(seen_done[0]), '0);
    push(0, rnd512(), '1, 1'b1, 8'h09);
    run_frame(0, 64, 20, n);
    chk("f6b_latency", 0, wide_t'(n), wide_t'(2));
    chk("f6b_len", 0, wide_t'(d_len[0]), wide_t'(64));

    // Zero-length descriptor: done next cycle, the waiting beat is never taken.
    push(0, rnd512(), '1, 1'b1, 8'h0A);
    run_frame(0, 0, 20, n);
    chk("f7_latency", 0, wide_t'(n), wide_t'(1));
    chk("f7_len", 0, wide_t'(d_len[0]), '0);
    chk("f7_err_len", 0, wide_t'(d_el[0]), '0);
    tick();
    tick();
    tick();
    chk("f7_tready_never", 0, wide_t'(rdy_seen[0]), '0);
    flush(0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/net_rx_sink.md
Name: net_rx_sink

Overview:
Network-side receive endpoint for simulation and top-level bring-up. It is the sink for the AXI-stream that the DUT transmits toward the network, the counterpart of the network source that drives m_net_axis into the DUT. For each descriptor (net_rstart plus an expected length), it accepts one frame with a programmable backpressure pattern. It re-presents every beat on a registered net_data_out bus, counts the received bytes, and reports completion and length, tlast and keep errors.

Parameters:
AXIS_DATA_WIDTH, 512, stream data width in bits; must equal ROWS*INPUT_LENGTH
AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width
AXIS_USER_WIDTH, 8, tuser width
LEN_WIDTH, 20, byte length/counter width
ROWS, 32, output row count
INPUT_LENGTH, 16, bits per row
READY_PATTERN, 16'hFFFF, tready pattern applied in RECV; bit i is used on RECV cycle i mod 16

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_net_axis_tdata  in  AXIS_DATA_WIDTH  frame data from DUT
s_net_axis_tkeep  in  AXIS_KEEP_WIDTH  byte enables
s_net_axis_tlast  in  1  end of frame
s_net_axis_tuser  in  AXIS_USER_WIDTH  sideband; captured on the last beat only
s_net_axis_tvalid  in  1  beat valid
s_net_axis_tready  out  1  sink ready
net_rstart  in  1  descriptor strobe; accepted only in IDLE
net_rdesc_len  in  LEN_WIDTH  expected frame length in bytes
net_data_out  out  ROWS*INPUT_LENGTH  registered copy of the accepted tdata
net_valid_out  out  1  net_data_out valid, one cycle per accepted beat
net_data_tkeep_out  out  AXIS_KEEP_WIDTH  registered tkeep
net_data_tlast_out  out  1  registered tlast
net_rx_busy  out  1  high in RECV
net_rx_done  out  1  one-cycle completion pulse
net_rx_len  out  LEN_WIDTH  bytes received in the last frame; valid from net_rx_done until the next accepted start
net_rx_tuser  out  AXIS_USER_WIDTH  tuser of the last beat
net_rx_err_len  out  1  sticky: received byte count differs from net_rdesc_len
net_rx_err_keep  out  1  sticky: non-contiguous tkeep, or a partial tkeep on a non-last beat

Behaviour:
- Reset: state=IDLE, pattern pointer=0, byte counter=0. Every output is 0, including tready.
- FSM states: IDLE, RECV, DONE.
- IDLE:
  - tready=0.
  - net_rstart with len!=0: latch len, clear the counter and both error flags, clear the pointer, go to RECV.
  - net_rstart with len==0: go to DONE with count 0 and no errors, so the done pulse follows the start by 1 cycle.
- RECV:
  - net_rx_busy=1; tready=READY_PATTERN[ptr]; ptr increments every RECV cycle, wrapping at 16.
  - A beat is accepted when tvalid&tready. tvalid without tready changes nothing.
  - Per accepted beat: counter += popcount(tkeep), computed at LEN_WIDTH+1 bits internally and saturating at all-ones.
  - The beat is registered to net_data_out, net_data_tkeep_out and net_data_tlast_out with net_valid_out=1 on the next cycle; latency is 1.
  - net_valid_out is 0 in every cycle that follows a non-accepting cycle.
  - err_keep sets when tkeep is not of the form 0…01…1, or when tkeep is not all ones on a beat without tlast.
  - Accepted beat with tlast: capture tuser and go to DONE.
  - No frame timeout. net_rstart is ignored in RECV.
- DONE (exactly 1 cycle):
  - tready=0; net_rx_done=1, coincident with net_valid_out for the last beat.
  - net_rx_len = final count; err_len = (count != latched len).
  - Return to IDLE. net_rstart in this cycle is ignored.
- Error flags and net_rx_len hold until the next accepted net_rstart or rst.
- rst mid-frame aborts immediately: no done pulse, and any partial beat is dropped.
- Frame beats arriving in IDLE/DONE are stalled (tready=0), never dropped.

Test Plan:
- rstart len=128, DUT sends 2 full beats (tkeep all ones), last beat with tlast, READY_PATTERN=FFFF -> 2 net_valid_out pulses 1 cycle after each accept; done in the cycle after beat 2 is accepted; len=128; no errors.
- len=100, beat 1 tkeep all ones, beat 2 tkeep=0x0000000F_FFFFFFFF with tlast -> len=100, err_len=0, err_keep=0.
- len=64, DUT sends 2 full beats with tlast on beat 2 -> len=128, err_len=1; rstart len=64 with a correct 1-beat frame then clears it.
- READY_PATTERN=16'h5555, 4-beat frame with continuous tvalid -> tready alternates starting at 1; beats are accepted only on even RECV cycles; data order is preserved; done arrives 8 RECV cycles after start.
- Non-last beat tkeep=0x0F, then tkeep=0x0F00 with tlast -> err_keep=1; byte count still equals the sum of popcounts.
- rst asserted mid-frame after 1 of 3 beats -> all outputs 0 the next cycle, no done pulse; a new rstart then receives normally.
- rstart len=0 -> done 1 cycle later with len=0; tready stays 0 throughout.
